// File: rtl/pkt_tx_sched.sv
// Transmit scheduler for the UDP OutFIFO: queues packet lengths and issues each
// one to the FIFO once enough bytes are buffered, then manages start/clear/status.
module pkt_tx_sched #(
    parameter int QDEPTH      = 4,
    parameter int LEN_W       = 16,
    parameter int PTR_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk_axi,
    input  logic             rst_axi,
    input  logic             req_valid_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             req_ready_o,
    input  logic             clear_req_i,
    output logic             cmd_start_o,
    output logic [LEN_W-1:0] cmd_length_o,
    output logic             cmd_clear_o,
    input  logic             st_done_i,
    input  logic [PTR_W-1:0] st_wr_ptr_i,
    input  logic [PTR_W-1:0] st_rd_ptr_i,
    output logic             busy_o,
    output logic             err_o,
    output logic [15:0]      sent_cnt_o,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_REL   = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int CW = (LEN_W > PTR_W) ? LEN_W : PTR_W;
    localparam logic [AW:0] Q_FULL_CNT = (AW+1)'(QDEPTH);

    logic [LEN_W-1:0] q_mem [QDEPTH];
    logic [AW-1:0]    q_wr;
    logic [AW-1:0]    q_rd;
    logic [AW:0]      q_cnt;
    logic             q_full;
    logic             q_empty;

    state_t           state;
    logic [TW-1:0]    run_cnt;
    logic [PTR_W-1:0] avail;
    logic [CW-1:0]    avail_ext;
    logic [CW-1:0]    len_ext;
    logic             timeout_hit;
    logic             flush;
    logic             req_fire;
    logic             push_fire;
    logic             pop_fire;
    logic             zero_len;

    // Request handshake: a request transfers on a cycle where req_valid_i and
    // req_ready_o are both high; req_ready_o depends only on queue occupancy.
    assign q_full      = (q_cnt == Q_FULL_CNT);
    assign q_empty     = (q_cnt == '0);
    assign req_ready_o = ~q_full;
    assign req_fire    = req_valid_i && !q_full;
    assign zero_len    = req_fire && (req_len_i == '0);

    // Wrap-safe fill level of the packet FIFO.
    assign avail     = st_wr_ptr_i - st_rd_ptr_i;
    assign avail_ext = CW'(avail);
    assign len_ext   = CW'(cmd_length_o);

    assign timeout_hit = (TIMEOUT_CYC != 0) && (run_cnt == TW'(TIMEOUT_CYC - 1));
    assign flush       = clear_req_i || ((state == S_RUN) && !st_done_i && timeout_hit);
    assign push_fire   = req_fire && !zero_len && !flush;
    assign pop_fire    = (state == S_IDLE) && !q_empty && !clear_req_i;

    assign busy_o    = (state != S_IDLE) || !q_empty;
    assign dbg_state = state;

    always_ff @(posedge clk_axi) begin
        if (push_fire) begin
            q_mem[q_wr] <= req_len_i;
        end
    end

    always_ff @(posedge clk_axi or posedge rst_axi) begin
        if (rst_axi) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else if (flush) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (push_fire) begin
                q_wr <= q_wr + AW'(1);
            end
            if (pop_fire) begin
                q_rd <= q_rd + AW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   q_cnt <= q_cnt + (AW+1)'(1);
                2'b01:   q_cnt <= q_cnt - (AW+1)'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Start and clear are registered so each mirrors exactly one state.
    always_ff @(posedge clk_axi or posedge rst_axi) begin
        if (rst_axi) begin
            state        <= S_IDLE;
            cmd_start_o  <= 1'b0;
            cmd_clear_o  <= 1'b0;
            cmd_length_o <= '0;
            run_cnt      <= '0;
            err_o        <= 1'b0;
            sent_cnt_o   <= '0;
        end else begin
            cmd_start_o <= 1'b0;
            cmd_clear_o <= 1'b0;
            if (clear_req_i) begin
                state       <= S_CLR;
                cmd_clear_o <= 1'b1;
                err_o       <= 1'b0;
            end else begin
                if (zero_len) begin
                    err_o <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (!q_empty) begin
                            cmd_length_o <= q_mem[q_rd];
                            state        <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (avail_ext >= len_ext) begin
                            state       <= S_RUN;
                            cmd_start_o <= 1'b1;
                            run_cnt     <= '0;
                        end
                    end
                    S_RUN: begin
                        if (st_done_i) begin
                            state      <= S_REL;
                            sent_cnt_o <= sent_cnt_o + 16'd1;
                        end else if (timeout_hit) begin
                            state       <= S_CLR;
                            cmd_clear_o <= 1'b1;
                            err_o       <= 1'b1;
                        end else begin
                            cmd_start_o <= 1'b1;
                            run_cnt     <= run_cnt + TW'(1);
                        end
                    end
                    S_REL:   state <= S_IDLE;
                    S_CLR:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
